// File: rtl/sweep_response_detector_if.sv
// sweep_response_detector_if: sample stream, generator step handshake and per-step result bus
interface sweep_response_detector_if #(
  parameter int DW = 12,
  parameter int NLOG2 = 8,
  parameter int SW = 6
);
  logic start;
  logic s_valid;
  logic signed [DW-1:0] s_data;
  logic step_req;
  logic step_ack;
  logic busy;
  logic acc_valid;
  logic [DW+NLOG2-1:0] acc_out;
  logic [SW-1:0] step_idx;
  logic [SW-1:0] peak_idx;
  logic [DW+NLOG2-1:0] peak_val;
  logic done;
  modport master (
    output start, s_valid, s_data, step_ack,
    input step_req, busy, acc_valid, acc_out, step_idx, peak_idx, peak_val, done
  );
  modport slave (
    input start, s_valid, s_data, step_ack,
    output step_req, busy, acc_valid, acc_out, step_idx, peak_idx, peak_val, done
  );
endinterface

// File: rtl/sweep_response_detector.sv
// sweep_response_detector: per-step settle/accumulate of |sample| over a frequency sweep,
// reporting each step's magnitude and tracking the step of peak response.
module sweep_response_detector #(
  parameter int DW = 12,
  parameter int NLOG2 = 8,
  parameter int SETTLE = 16,
  parameter int NSTEP = 64,
  parameter int SW = 6
) (
  input logic clk,
  input logic rst_n,
  sweep_response_detector_if.slave bus
);
  localparam int AW = DW + NLOG2;
  localparam int CW = (NLOG2 > $clog2(SETTLE) ? NLOG2 : $clog2(SETTLE)) + 1;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_ACCUM, ST_REPORT, ST_NEXT, ST_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step;
  logic [AW-1:0] acc, acc_next;
  logic [DW-1:0] neg, mag;
  // negating the most-negative code leaves its sign bit set; that case clamps to full scale
  assign neg = DW'(~bus.s_data) + DW'(1);
  assign mag = !bus.s_data[DW-1] ? DW'(bus.s_data) : neg[DW-1] ? {1'b0, {(DW-1){1'b1}}} : neg;
  assign acc_next = acc + AW'(mag);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      step <= '0;
      acc <= '0;
      bus.step_req <= 1'b0;
      bus.busy <= 1'b0;
      bus.acc_valid <= 1'b0;
      bus.acc_out <= '0;
      bus.step_idx <= '0;
      bus.peak_idx <= '0;
      bus.peak_val <= '0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          bus.peak_idx <= '0;
          bus.peak_val <= '0;
          bus.busy <= 1'b1;
          step <= '0;
          cnt <= '0;
          acc <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: if (bus.s_valid) begin
          cnt <= cnt == CW'(SETTLE - 1) ? '0 : cnt + CW'(1);
          if (cnt == CW'(SETTLE - 1)) state <= ST_ACCUM;
        end
        ST_ACCUM: if (bus.s_valid) begin
          acc <= acc_next;
          cnt <= cnt == CW'((1 << NLOG2) - 1) ? '0 : cnt + CW'(1);
          if (cnt == CW'((1 << NLOG2) - 1)) begin
            bus.acc_out <= acc_next;
            bus.step_idx <= step;
            bus.acc_valid <= 1'b1;
            state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          bus.acc_valid <= 1'b0;
          // strict compare keeps the earlier step on ties
          if (bus.acc_out > bus.peak_val) begin
            bus.peak_val <= bus.acc_out;
            bus.peak_idx <= step;
          end
          if (step == SW'(NSTEP - 1)) begin
            bus.done <= 1'b1;
            state <= ST_DONE;
          end else begin
            bus.step_req <= 1'b1;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: if (bus.step_ack) begin
          bus.step_req <= 1'b0;
          step <= step + SW'(1);
          acc <= '0;
          state <= ST_SETTLE;
        end
        ST_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
